counter_seq_ctrl: RTL and testbench

//   Sequencer for the shared 8-bit up-counter datapath. Accepts commands over a valid/ready port.

---
 rtl/counter_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_counter_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - command sequencer driving the 8-bit up-counter through a prescaler
// Optional pause input enabled by defining CNT_SEQ_PAUSE_EN.
module counter_seq_ctrl #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [WIDTH-1:0]      cmd_arg,
   input  logic [PRESCALE_W-1:0] cfg_div,
   input  logic [WIDTH-1:0]      cnt_val,
   output logic                  cnt_clr,
   output logic                  cnt_inc,
   output logic                  busy,
   output logic                  done,
   output logic                  wrap,
`ifdef CNT_SEQ_PAUSE_EN
   output logic                  err,
   input  logic                  pause
`else
   output logic                  err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

   localparam logic [1:0] OP_RUN_TO   = 2'b01;
   localparam logic [1:0] OP_PERIODIC = 2'b10;
   localparam logic [1:0] OP_STOP     = 2'b11;

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        limit_q, limit_d;
   logic [PRESCALE_W-1:0]   div_q, div_d;
   logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
   logic                    periodic_q, periodic_d;
   logic                    err_q, err_d;
   logic                    pause_w;
   logic                    accept, is_start, is_stop;

`ifdef CNT_SEQ_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
   assign accept    = cmd_valid && cmd_ready;
   assign is_start  = (cmd_op == OP_RUN_TO) || (cmd_op == OP_PERIODIC);
   assign is_stop   = (cmd_op == OP_STOP);
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         limit_q    <= '0;
         div_q      <= '0;
         pcnt_q     <= '0;
         periodic_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         div_q      <= div_d;
         pcnt_q     <= pcnt_d;
         periodic_q <= periodic_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      div_d      = div_q;
      pcnt_d     = pcnt_q;
      periodic_d = periodic_q;
      err_d      = err_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      done       = 1'b0;
      wrap       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && is_start) begin
               limit_d    = cmd_arg;
               div_d      = cfg_div;
               periodic_d = (cmd_op == OP_PERIODIC);
               err_d      = 1'b0;
               state_d    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_clr = 1'b1;
            pcnt_d  = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // A STOP suppresses every strobe, even on a tick at the limit.
            if (accept && is_stop) begin
               pcnt_d  = '0;
               state_d = S_IDLE;
            end else begin
               if (accept && is_start) err_d = 1'b1;
               if (!pause_w) begin
                  if (pcnt_q == div_q) begin
                     pcnt_d = '0;
                     if (cnt_val != limit_q) begin
                        cnt_inc = 1'b1;
                     end else if (periodic_q) begin
                        cnt_clr = 1'b1;
                        wrap    = 1'b1;
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     pcnt_d = pcnt_q + 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - directed scoreboard bench for counter_seq_ctrl
// Pause scenario is included when CNT_SEQ_PAUSE_EN is defined.
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_arg = 8'd0;
   logic [3:0] cfg_div = 4'd0;
   logic [7:0] cnt_val;
   logic       cnt_clr, cnt_inc, busy, done, wrap, err;
`ifdef CNT_SEQ_PAUSE_EN
   logic       pause = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];
   int         lat_q[$];

   always #5 clk = ~clk;

   counter_seq_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cfg_div(cfg_div), .cnt_val(cnt_val),
      .cnt_clr(cnt_clr), .cnt_inc(cnt_inc), .busy(busy), .done(done),
`ifdef CNT_SEQ_PAUSE_EN
      .wrap(wrap), .err(err), .pause(pause)
`else
      .wrap(wrap), .err(err)
`endif
   );

   // Counter datapath stand-in driven by the controller strobes.
   logic [7:0] cnt_r = 8'd0;
   assign cnt_val = cnt_r;
   always @(posedge clk) begin
      if (!rst_n)       cnt_r <= 8'd0;
      else if (cnt_clr) cnt_r <= 8'd0;
      else if (cnt_inc) cnt_r <= cnt_r + 8'd1;
   end

   // Expected vector order: {ready, busy, clr, inc, done, wrap, err}
   task automatic step(input logic r, input logic v, input logic [1:0] op,
                       input logic [7:0] arg, input logic [3:0] dv,
                       input logic [6:0] exp, input string tag);
      logic [6:0] obs, e;
      @(posedge clk);
      #1;
      rst_n = r; cmd_valid = v; cmd_op = op; cmd_arg = arg; cfg_div = dv;
      exp_q.push_back(exp);
      @(negedge clk);
      obs = {cmd_ready, busy, cnt_clr, cnt_inc, done, wrap, err};
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
   endtask

   task automatic idle(input logic [6:0] exp, input string tag);
      step(1'b1, 1'b0, 2'b00, 8'd0, 4'd0, exp, tag);
   endtask

   task automatic chk_cnt(input logic [7:0] exp, input string tag);
      checks++;
      assert (cnt_val === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, cnt_val, exp);
      end
   endtask

   // Counts cycles after the accept cycle until done; 0 if never seen.
   task automatic wait_done(input bit use_pause, output int lat, output int incs);
      bit seen;
      lat = 0; incs = 0; seen = 0;
      for (int k = 1; k <= 30 && !seen; k++) begin
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
`ifdef CNT_SEQ_PAUSE_EN
         pause = use_pause && (k >= 2) && (k <= 6);
`endif
         @(negedge clk);
         if (cnt_inc) incs++;
         if (done) begin seen = 1; lat = k; end
      end
`ifdef CNT_SEQ_PAUSE_EN
      pause = 1'b0;
`endif
   endtask

   initial begin
      int lat, incs, exp_lat;

      step(1'b0, 1'b0, 2'b00, 8'd0, 4'd0, 7'b1000000, "reset");
      idle(7'b1000000, "reset_release");

      // RUN_TO limit 3, div 0
      step(1'b1, 1'b1, 2'b01, 8'd3, 4'd0, 7'b1000000, "rt3_accept");
      idle(7'b0110000, "rt3_clear");
      idle(7'b1101000, "rt3_inc0");
      idle(7'b1101000, "rt3_inc1");
      idle(7'b1101000, "rt3_inc2");
      idle(7'b1100000, "rt3_at_limit");
      idle(7'b0100100, "rt3_done");
      idle(7'b1000000, "rt3_idle");
      chk_cnt(8'd3, "rt3_cnt");

      // PERIODIC limit 2, div 1, then STOP on a tick
      step(1'b1, 1'b1, 2'b10, 8'd2, 4'd1, 7'b1000000, "per_accept");
      idle(7'b0110000, "per_clear");
      idle(7'b1100000, "per_c0a");
      idle(7'b1101000, "per_c0b");
      idle(7'b1100000, "per_c1a");
      idle(7'b1101000, "per_c1b");
      idle(7'b1100000, "per_c2a");
      idle(7'b1110010, "per_wrap");
      idle(7'b1100000, "per2_c0a");
      idle(7'b1101000, "per2_c0b");
      idle(7'b1100000, "per2_c1a");
      step(1'b1, 1'b1, 2'b11, 8'd0, 4'd0, 7'b1100000, "per_stop");
      idle(7'b1000000, "per_idle");
      chk_cnt(8'd1, "per_cnt_held");

      // RUN_TO limit 0, div 3: latency and no increments
      step(1'b1, 1'b1, 2'b01, 8'd0, 4'd3, 7'b1000000, "rt0_accept");
      lat_q.push_back(6);
      wait_done(1'b0, lat, incs);
      exp_lat = lat_q.pop_front();
      checks++;
      assert (lat === exp_lat) else begin
         errors++;
         $error("FAIL rt0_latency observed=%0d expected=%0d", lat, exp_lat);
      end
      checks++;
      assert (incs === 0) else begin
         errors++;
         $error("FAIL rt0_no_inc observed=%0d expected=0", incs);
      end
      idle(7'b1000000, "rt0_idle");

      // Start command during RUN sets sticky err; next IDLE accept clears it
      step(1'b1, 1'b1, 2'b01, 8'd5, 4'd0, 7'b1000000, "err_accept");
      idle(7'b0110000, "err_clear");
      step(1'b1, 1'b1, 2'b10, 8'd9, 4'd0, 7'b1101000, "err_cmd");
      idle(7'b1101001, "err_set");
      idle(7'b1101001, "err_run_on");
      step(1'b1, 1'b1, 2'b11, 8'd0, 4'd0, 7'b1100001, "err_stop");
      idle(7'b1000001, "err_idle");
      step(1'b1, 1'b1, 2'b01, 8'd0, 4'd0, 7'b1000001, "err_reaccept");
      idle(7'b0110000, "err_cleared");
      idle(7'b1100000, "lim0_tick");
      idle(7'b0100100, "lim0_done");
      idle(7'b1000000, "lim0_idle");

      // STOP coincides with a tick at limit
      step(1'b1, 1'b1, 2'b01, 8'd1, 4'd0, 7'b1000000, "sl_accept");
      idle(7'b0110000, "sl_clear");
      idle(7'b1101000, "sl_inc");
      step(1'b1, 1'b1, 2'b11, 8'd0, 4'd0, 7'b1100000, "sl_stop_tick");
      idle(7'b1000000, "sl_idle");

      // Reset mid-PERIODIC
      step(1'b1, 1'b1, 2'b10, 8'd7, 4'd0, 7'b1000000, "rst_accept");
      idle(7'b0110000, "rst_clear");
      idle(7'b1101000, "rst_run");
      step(1'b0, 1'b0, 2'b00, 8'd0, 4'd0, 7'b1101000, "rst_assert");
      idle(7'b1000000, "rst_after");

`ifdef CNT_SEQ_PAUSE_EN
      step(1'b1, 1'b1, 2'b01, 8'd0, 4'd0, 7'b1000000, "pause_accept");
      lat_q.push_back(8);
      wait_done(1'b1, lat, incs);
      exp_lat = lat_q.pop_front();
      checks++;
      assert (lat === exp_lat) else begin
         errors++;
         $error("FAIL pause_latency observed=%0d expected=%0d", lat, exp_lat);
      end
      idle(7'b1000000, "pause_idle");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
